// File: rtl/bomb_game_pkg.sv
// +--------------------------------------------------------------------------+
// | bomb_game_pkg: shared command types for the bomb game engine.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package bomb_game_pkg;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    STOP  = 3'd4
  } dir_t;

  typedef logic player_t;

  typedef struct packed {
    player_t player;
    dir_t    dir;
    logic    bomb;
  } cmd_t;

  localparam cmd_t CMD_RESET = '{player: 1'b0, dir: STOP, bomb: 1'b0};

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +--------------------------------------------------------------------------+
// | rr_arb2: combinational two-requester round-robin grant.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import bomb_game_pkg::*;
(
  input  logic [1:0] req,
  input  player_t    ptr,
  output player_t    gnt,
  output logic       any
);

  // ptr names the last served requester; on a tie the other one wins
  always_comb begin
    any = |req;
    if (req == 2'b11) gnt = ~ptr;
    else              gnt = req[1];
  end

endmodule

`default_nettype wire

// File: rtl/player_cmd_arbiter.sv
// +--------------------------------------------------------------------------+
// | player_cmd_arbiter: per-player move/bomb slots, move cooldown and        |
// | round-robin issue onto the map-update port. Option: BOMB_PRIORITY_EN.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module player_cmd_arbiter
  import bomb_game_pkg::*;
#(
  parameter int COOLDOWN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       tick,
  input  logic       valid_1,
  input  logic [2:0] dir_1,
  input  logic       bomb_1,
  input  logic       valid_2,
  input  logic [2:0] dir_2,
  input  logic       bomb_2,
  input  logic       map_ready,
  output logic       map_valid,
  output logic       map_player,
  output logic [2:0] map_dir,
  output logic       map_bomb,
  output logic       pend_1,
  output logic       pend_2
);

  localparam int CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [1:0]      move_pend, move_pend_nxt;
  logic [1:0]      bomb_pend, bomb_pend_nxt;
  logic [2:0]      move_dir [2];
  logic [2:0]      move_dir_nxt [2];
  logic [CD_W-1:0] cooldown [2];
  logic [1:0]      valid_v, bomb_v, bomb_el, move_el, req;
  logic [2:0]      dir_v [2];
  player_t         rr_ptr, gnt;
  logic            any_req, issue_start, issue_bomb, accept;
  cmd_t            map_cmd;

  assign valid_v  = {valid_2, valid_1};
  assign bomb_v   = {bomb_2, bomb_1};
  assign dir_v[0] = dir_1;
  assign dir_v[1] = dir_2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      bomb_el[p] = bomb_pend[p];
      move_el[p] = move_pend[p] && (cooldown[p] == '0);
    end
  end

`ifdef BOMB_PRIORITY_EN
  assign req = (|bomb_el) ? bomb_el : move_el;
`else
  assign req = bomb_el | move_el;
`endif

  rr_arb2 u_rr_arb2 (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .any (any_req)
  );

  assign issue_start = (state == S_IDLE) && game_active && any_req;
  assign issue_bomb  = bomb_el[gnt];
  assign accept      = (state == S_ISSUE) && map_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (issue_start) state_nxt = S_ISSUE;
      S_ISSUE: if (map_ready)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    map_valid = (state == S_ISSUE);
  end

  // A fresh request in the consume cycle is applied after the consume clear
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      move_pend_nxt[p] = move_pend[p];
      bomb_pend_nxt[p] = bomb_pend[p];
      move_dir_nxt[p]  = move_dir[p];
      if (issue_start && (gnt == p[0])) begin
        if (issue_bomb) bomb_pend_nxt[p] = 1'b0;
        else            move_pend_nxt[p] = 1'b0;
      end
      if (valid_v[p]) begin
        if (bomb_v[p]) begin
          bomb_pend_nxt[p] = 1'b1;
        end else if (dir_v[p] == STOP) begin
          move_pend_nxt[p] = 1'b0;
        end else begin
          move_pend_nxt[p] = 1'b1;
          move_dir_nxt[p]  = dir_v[p];
        end
      end
      if (!game_active) begin
        move_pend_nxt[p] = 1'b0;
        bomb_pend_nxt[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_pend <= '0;
      bomb_pend <= '0;
      pend_1    <= 1'b0;
      pend_2    <= 1'b0;
      for (int p = 0; p < 2; p++) move_dir[p] <= STOP;
    end else begin
      move_pend <= move_pend_nxt;
      bomb_pend <= bomb_pend_nxt;
      pend_1    <= move_pend_nxt[0] | bomb_pend_nxt[0];
      pend_2    <= move_pend_nxt[1] | bomb_pend_nxt[1];
      for (int p = 0; p < 2; p++) move_dir[p] <= move_dir_nxt[p];
    end
  end

  // Cooldown load on move acceptance takes precedence over a same-cycle tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) cooldown[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (accept && (map_cmd.player == p[0]) && !map_cmd.bomb)
          cooldown[p] <= CD_W'(COOLDOWN_TICKS);
        else if (tick && (cooldown[p] != '0))
          cooldown[p] <= cooldown[p] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_cmd <= CMD_RESET;
      rr_ptr  <= 1'b1;
    end else begin
      if (issue_start) begin
        map_cmd.player <= gnt;
        map_cmd.bomb   <= issue_bomb;
        map_cmd.dir    <= issue_bomb ? STOP : dir_t'(move_dir[gnt]);
      end
      if (accept) rr_ptr <= map_cmd.player;
    end
  end

  assign map_player = map_cmd.player;
  assign map_dir    = map_cmd.dir;
  assign map_bomb   = map_cmd.bomb;

endmodule

`default_nettype wire

// File: tb/tb_player_cmd_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_player_cmd_arbiter: directed and random checks against a ref model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_player_cmd_arbiter;

  localparam int CD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_active = 1'b0, tick = 1'b0, map_ready = 1'b0;
  logic       valid_1 = 1'b0, bomb_1 = 1'b0, valid_2 = 1'b0, bomb_2 = 1'b0;
  logic [2:0] dir_1 = 3'd0, dir_2 = 3'd0;
  logic       map_valid, map_player, map_bomb, pend_1, pend_2;
  logic [2:0] map_dir;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_mv [2];
  bit m_bm [2];
  int m_md [2];
  int m_cd [2];
  bit m_busy;
  int m_cur_p, m_cur_d, m_last;
  bit m_cur_b;

  player_cmd_arbiter #(.COOLDOWN_TICKS(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .game_active(game_active),
    .tick       (tick),
    .valid_1    (valid_1),
    .dir_1      (dir_1),
    .bomb_1     (bomb_1),
    .valid_2    (valid_2),
    .dir_2      (dir_2),
    .bomb_2     (bomb_2),
    .map_ready  (map_ready),
    .map_valid  (map_valid),
    .map_player (map_player),
    .map_dir    (map_dir),
    .map_bomb   (map_bomb),
    .pend_1     (pend_1),
    .pend_2     (pend_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_mv[p] = 0; m_bm[p] = 0; m_md[p] = 4; m_cd[p] = 0;
    end
    m_busy = 0; m_cur_p = 0; m_cur_d = 4; m_cur_b = 0; m_last = 1;
  endtask

  // One clock of the rules, applied to the pre-edge model state
  task automatic model_update();
    bit eb [2];
    bit em [2];
    bit rq [2];
    bit acc, start, wb, any_b;
    int win;
    bit vld [2];
    bit bmb [2];
    int dr [2];
    vld[0] = valid_1; vld[1] = valid_2;
    bmb[0] = bomb_1;  bmb[1] = bomb_2;
    dr[0]  = int'(dir_1); dr[1] = int'(dir_2);
    acc = m_busy && map_ready;
    any_b = 0;
    for (int p = 0; p < 2; p++) begin
      eb[p] = m_bm[p];
      em[p] = m_mv[p] && (m_cd[p] == 0);
      any_b |= eb[p];
    end
    for (int p = 0; p < 2; p++) begin
`ifdef BOMB_PRIORITY_EN
      rq[p] = any_b ? eb[p] : em[p];
`else
      rq[p] = eb[p] || em[p];
`endif
    end
    start = !m_busy && game_active && (rq[0] || rq[1]);
    if (rq[0] && rq[1]) win = 1 - m_last;
    else                win = rq[1] ? 1 : 0;
    wb = eb[win];
    for (int p = 0; p < 2; p++) begin
      if (acc && m_cur_p == p && !m_cur_b) m_cd[p] = CD;
      else if (tick && m_cd[p] > 0)        m_cd[p] = m_cd[p] - 1;
    end
    if (acc) m_last = m_cur_p;
    if (start) begin
      m_cur_p = win;
      m_cur_b = wb;
      m_cur_d = wb ? 4 : m_md[win];
    end
    for (int p = 0; p < 2; p++) begin
      if (start && win == p) begin
        if (wb) m_bm[p] = 0;
        else    m_mv[p] = 0;
      end
      if (vld[p]) begin
        if (bmb[p])          m_bm[p] = 1;
        else if (dr[p] == 4) m_mv[p] = 0;
        else begin m_mv[p] = 1; m_md[p] = dr[p]; end
      end
      if (!game_active) begin m_mv[p] = 0; m_bm[p] = 0; end
    end
    if (acc)        m_busy = 0;
    else if (start) m_busy = 1;
  endtask

  task automatic compare_all();
    chk("map_valid", map_valid, m_busy);
    chk("map_player", map_player, m_cur_p);
    chk("map_dir", map_dir, m_cur_d);
    chk("map_bomb", map_bomb, m_cur_b);
    chk("pend_1", pend_1, m_mv[0] | m_bm[0]);
    chk("pend_2", pend_2, m_mv[1] | m_bm[1]);
  endtask

  task automatic step(input bit ga, input bit tk,
                      input bit v1, input int d1, input bit b1,
                      input bit v2, input int d2, input bit b2,
                      input bit rdy);
    @(negedge clk);
    game_active = ga; tick = tk; map_ready = rdy;
    valid_1 = v1; dir_1 = 3'(d1); bomb_1 = b1;
    valid_2 = v2; dir_2 = 3'(d2); bomb_2 = b2;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    game_active = 0; tick = 0; map_ready = 0;
    valid_1 = 0; valid_2 = 0; bomb_1 = 0; bomb_2 = 0; dir_1 = 0; dir_2 = 0;
    #1;
    chk("rst_async_valid", map_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_player", map_player, 1'b0);
    chk("rst_dir", map_dir, 3'd4);
    chk("rst_bomb", map_bomb, 1'b0);
    chk("rst_pend_1", pend_1, 1'b0);
    chk("rst_pend_2", pend_2, 1'b0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // basic move with backpressure
    step(1,0, 1,2,0, 0,0,0, 0);
    chk("mv_lat1_valid", map_valid, 1'b0);
    chk("mv_lat1_pend", pend_1, 1'b1);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("mv_valid", map_valid, 1'b1);
    chk("mv_player", map_player, 1'b0);
    chk("mv_dir", map_dir, 3'd2);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("mv_hold", map_valid, 1'b1);
    step(1,0, 0,0,0, 0,0,0, 1);
    chk("mv_drop", map_valid, 1'b0);

    // cooldown: next move waits for two ticks
    step(1,0, 1,1,0, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("cd_blocked0", map_valid, 1'b0);
    step(1,1, 0,0,0, 0,0,0, 0);
    chk("cd_blocked1", map_valid, 1'b0);
    step(1,1, 0,0,0, 0,0,0, 0);
    chk("cd_blocked2", map_valid, 1'b0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("cd_issue", map_valid, 1'b1);
    chk("cd_dir", map_dir, 3'd1);
    step(1,0, 0,0,0, 0,0,0, 1);

    // bomb during cooldown goes out at once and leaves cooldown alone
    step(1,0, 1,0,1, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("bomb_valid", map_valid, 1'b1);
    chk("bomb_flag", map_bomb, 1'b1);
    chk("bomb_dir", map_dir, 3'd4);
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 1,0,0, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("bomb_cd_kept", map_valid, 1'b0);
    step(1,1, 0,0,0, 0,0,0, 0);
    step(1,1, 0,0,0, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("after_cd_up", map_dir, 3'd0);
    step(1,0, 0,0,0, 0,0,0, 1);

    // simultaneous strobes, tie goes to player 1 after reset
    do_reset();
    step(1,0, 1,0,0, 1,3,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);
    chk("tie_first", map_player, 1'b0);
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);
    chk("tie_second", map_player, 1'b1);
    chk("tie_second_dir", map_dir, 3'd3);
    step(1,0, 0,0,0, 0,0,0, 1);
    for (int i = 0; i < 3; i++) step(1,1, 0,0,0, 0,0,0, 1);
    step(1,0, 1,2,0, 1,1,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 0,0,0, 0,0,0, 1);

    // move vs bomb tie with pointer favouring player 1
    do_reset();
    step(1,0, 1,2,0, 1,0,1, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
`ifdef BOMB_PRIORITY_EN
    chk("prio_player", map_player, 1'b1);
    chk("prio_bomb", map_bomb, 1'b1);
`else
    chk("prio_player", map_player, 1'b0);
    chk("prio_bomb", map_bomb, 1'b0);
`endif
    step(1,0, 0,0,0, 0,0,0, 1);
    step(1,0, 0,0,0, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 1);

    // game_active drop while a command is in flight
    do_reset();
    step(1,0, 1,3,0, 1,1,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("ga_pend_2", pend_2, 1'b1);
    step(0,0, 0,0,0, 0,0,0, 0);
    chk("ga_inflight", map_valid, 1'b1);
    chk("ga_pend_2_clr", pend_2, 1'b0);
    step(0,0, 0,0,0, 0,0,0, 1);
    chk("ga_done", map_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0,1, 0,0,0, 0,0,0, 1);
      chk("ga_quiet", map_valid, 1'b0);
    end

    // reset mid-issue drops map_valid asynchronously
    do_reset();
    step(1,0, 1,0,0, 0,0,0, 0);
    step(1,0, 0,0,0, 0,0,0, 0);
    chk("pre_rst_valid", map_valid, 1'b1);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
